// File: rtl/move_pkg.sv
// Shared definitions for the move command scheduler.
//   - PS/2 scan-code bytes recognised by the parser
//   - parser state encoding (legacy-compatible localparam constants)
//   - move direction encoding
//   - default command queue depth
package move_pkg;

    localparam int unsigned FIFO_DEPTH_DEF = 4;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    typedef logic [1:0] parse_state_t;
    localparam parse_state_t ST_IDLE    = 2'd0;
    localparam parse_state_t ST_BRK     = 2'd1;
    localparam parse_state_t ST_EXT     = 2'd2;
    localparam parse_state_t ST_EXT_BRK = 2'd3;

    typedef logic dir_t;
    localparam dir_t DIR_LEFT  = 1'b0;
    localparam dir_t DIR_RIGHT = 1'b1;

endpackage

// File: rtl/move_cmd_fifo.sv
// 1-bit wide command queue holding move directions.
// Ports:
//   clk, rst_n     clock, async active-low reset (pointers and count only)
//   flush          empties the queue; dominates push and pop
//   push/push_data write one entry (caller guarantees room or a same-cycle pop)
//   pop/pop_data   pop_data is the oldest entry, valid while !empty
//   count          number of stored entries
//   full/empty     status flags
module move_cmd_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     push_data,
    input  logic                     pop,
    output logic                     pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Depth is a power of two, so pointers wrap naturally.
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; only pointers and count matter.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);

endmodule

// File: rtl/move_cmd_sched.sv
// Move command scheduler: parses PS/2 extended break codes for the left/right
// arrow keys into queued move commands and applies one per frame while the
// play scene's expand phase is active.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   scan_code/valid keyboard byte stream
//   scene           bit 0 high = play scene
//   scene_posedge   scene change: resets lane, flushes queue, clears overflow
//   frame_done      end-of-frame strobe, dispatch opportunity
//   expand          dispatch enable
//   people          current lane (mod 4)
//   mv_valid/mv_dir one-cycle pulse and direction of the applied move
//   q_count         queued commands
//   overflow        sticky: a command was dropped on a full queue
module move_cmd_sched
    import move_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    scan_code,
    input  logic                          scan_valid,
    input  logic [1:0]                    scene,
    input  logic                          scene_posedge,
    input  logic                          frame_done,
    input  logic                          expand,
    output logic [1:0]                    people,
    output logic                          mv_valid,
    output logic                          mv_dir,
    output logic [$clog2(FIFO_DEPTH):0]   q_count,
    output logic                          overflow
);

    parse_state_t state_q, state_d;
    logic [1:0]   people_q, people_d;
    logic         mv_valid_q, mv_valid_d;
    dir_t         mv_dir_q, mv_dir_d;
    logic         overflow_q, overflow_d;

    logic enq, push, pop, dispatch;
    dir_t enq_dir, head_dir;
    logic fifo_full, fifo_empty;

    // Parser: only the sequence E0 F0 <6B|74> produces a command.
    always_comb begin
        state_d = state_q;
        enq     = 1'b0;
        enq_dir = DIR_LEFT;
        if (scan_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_code == SC_EXT)      state_d = ST_EXT;
                    else if (scan_code == SC_BRK) state_d = ST_BRK;
                    else                          state_d = ST_IDLE;
                end
                ST_BRK:  state_d = ST_IDLE;
                ST_EXT:  state_d = (scan_code == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
                default: begin
                    state_d = ST_IDLE;
                    if (scan_code == SC_LEFT) begin
                        enq     = 1'b1;
                        enq_dir = DIR_LEFT;
                    end else if (scan_code == SC_RIGHT) begin
                        enq     = 1'b1;
                        enq_dir = DIR_RIGHT;
                    end
                end
            endcase
        end
        if (scene_posedge) state_d = ST_IDLE;
    end

    assign dispatch = frame_done && scene[0] && expand && !scene_posedge;
    // No bypass: an empty queue never pops, even with a same-cycle enqueue.
    assign pop      = dispatch && !fifo_empty;
    // A full queue still accepts when a pop frees a slot on the same edge.
    assign push     = enq && !scene_posedge && (!fifo_full || pop);

    always_comb begin
        people_d   = people_q;
        mv_valid_d = 1'b0;
        mv_dir_d   = mv_dir_q;
        overflow_d = overflow_q;
        if (scene_posedge) begin
            people_d   = 2'd0;
            overflow_d = 1'b0;
        end else begin
            if (pop) begin
                mv_valid_d = 1'b1;
                mv_dir_d   = head_dir;
                people_d   = (head_dir == DIR_LEFT) ? people_q + 2'd1 : people_q - 2'd1;
            end
            if (enq && fifo_full && !pop) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            people_q   <= 2'd0;
            mv_valid_q <= 1'b0;
            mv_dir_q   <= DIR_LEFT;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            people_q   <= people_d;
            mv_valid_q <= mv_valid_d;
            mv_dir_q   <= mv_dir_d;
            overflow_q <= overflow_d;
        end
    end

    move_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (scene_posedge),
        .push      (push),
        .push_data (enq_dir),
        .pop       (pop),
        .pop_data  (head_dir),
        .count     (q_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign people   = people_q;
    assign mv_valid = mv_valid_q;
    assign mv_dir   = mv_dir_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_move_cmd_sched.sv
module tb_move_cmd_sched;

    localparam int unsigned D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic       scan_valid = 1'b0;
    logic [1:0] scene = 2'b01;
    logic       scene_posedge = 1'b0;
    logic       frame_done = 1'b0;
    logic       expand = 1'b1;
    logic [1:0] people;
    logic       mv_valid;
    logic       mv_dir;
    logic [2:0] q_count;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    move_cmd_sched #(
        .FIFO_DEPTH (D)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .scan_code     (scan_code),
        .scan_valid    (scan_valid),
        .scene         (scene),
        .scene_posedge (scene_posedge),
        .frame_done    (frame_done),
        .expand        (expand),
        .people        (people),
        .mv_valid      (mv_valid),
        .mv_dir        (mv_dir),
        .q_count       (q_count),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sv;
        logic [7:0] code;
        logic       fd;
        logic [1:0] scn;
        logic       ex;
        logic       sp;
        logic [1:0] e_people;
        logic       e_mvv;
        logic       e_dir;
        logic [2:0] e_qc;
        logic       e_ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input int p, input int v, input int d,
                             input int q, input int o);
        check({tag, ".people"}, int'(people), p);
        check({tag, ".mv_valid"}, int'(mv_valid), v);
        check({tag, ".mv_dir"}, int'(mv_dir), d);
        check({tag, ".q_count"}, int'(q_count), q);
        check({tag, ".overflow"}, int'(overflow), o);
    endtask

    // Apply inputs for one cycle and sample 1 time unit after the edge.
    task automatic drive(input logic sv, input logic [7:0] code, input logic fd,
                         input logic [1:0] scn, input logic ex, input logic sp);
        scan_valid    = sv;
        scan_code     = code;
        frame_done    = fd;
        scene         = scn;
        expand        = ex;
        scene_posedge = sp;
        @(posedge clk);
        #1;
    endtask

    task automatic byte_in(input logic [7:0] code, input logic ex);
        drive(1'b1, code, 1'b0, 2'b01, ex, 1'b0);
    endtask

    task automatic add(input logic sv, input logic [7:0] code, input logic fd,
                       input logic [1:0] scn, input logic ex, input logic sp,
                       input logic [1:0] p, input logic v, input logic d,
                       input logic [2:0] q, input logic o);
        vec_t r;
        r.sv = sv; r.code = code; r.fd = fd; r.scn = scn; r.ex = ex; r.sp = sp;
        r.e_people = p; r.e_mvv = v; r.e_dir = d; r.e_qc = q; r.e_ovf = o;
        tbl.push_back(r);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        scan_valid = 1'b0; frame_done = 1'b0; scene_posedge = 1'b0;
        #1;
        check_all("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Behavioural reference: lane counter, ordered queue of directions and the
    // byte prefix seen so far of a possible E0 F0 <key> release.
    int          m_people;
    bit          m_q[$];
    bit          m_ovf, m_mvv, m_dir;
    logic [7:0]  m_pre[$];

    task automatic model_step(input logic sv, input logic [7:0] code, input logic fd,
                              input logic [1:0] scn, input logic ex, input logic sp);
        bit have_cmd, cmd_dir, popped;
        have_cmd = 0; cmd_dir = 0; popped = 0;
        m_mvv = 0;
        if (sp) begin
            m_people = 0; m_q.delete(); m_ovf = 0; m_pre.delete();
            return;
        end
        if (sv) begin
            if (m_pre.size() == 0) begin
                if (code == 8'hE0 || code == 8'hF0) m_pre.push_back(code);
            end else if (m_pre.size() == 1 && m_pre[0] == 8'hE0 && code == 8'hF0) begin
                m_pre.push_back(code);
            end else if (m_pre.size() == 2) begin
                if (code == 8'h6B) begin have_cmd = 1; cmd_dir = 0; end
                if (code == 8'h74) begin have_cmd = 1; cmd_dir = 1; end
                m_pre.delete();
            end else begin
                m_pre.delete();
            end
        end
        if (fd && scn[0] && ex && m_q.size() > 0) begin
            popped = 1;
            m_dir = m_q.pop_front();
            m_mvv = 1;
            m_people = m_dir ? (m_people + 3) % 4 : (m_people + 1) % 4;
        end
        if (have_cmd) begin
            if (m_q.size() < D) m_q.push_back(cmd_dir);
            else m_ovf = 1;
        end
    endtask

    initial begin
        // Reset state
        #3;
        check_all("reset0", 0, 0, 0, 0, 0);
        #19 rst_n = 1'b1;

        // sv code fd scn ex sp -> people mvv dir qc ovf
        add(1, 8'hE0, 0, 2'b01, 1, 0, 0, 0, 0, 0, 0);
        add(1, 8'hF0, 0, 2'b01, 1, 0, 0, 0, 0, 0, 0);
        add(1, 8'h6B, 0, 2'b01, 1, 0, 0, 0, 0, 1, 0);
        add(0, 8'h00, 1, 2'b01, 1, 0, 1, 1, 0, 0, 0);  // first LEFT move
        add(0, 8'h00, 0, 2'b01, 1, 0, 1, 0, 0, 0, 0);
        add(0, 8'h00, 0, 2'b01, 1, 1, 0, 0, 0, 0, 0);  // scene change -> lane 0
        add(1, 8'hE0, 0, 2'b01, 1, 0, 0, 0, 0, 0, 0);
        add(1, 8'hF0, 0, 2'b01, 1, 0, 0, 0, 0, 0, 0);
        add(1, 8'h74, 0, 2'b01, 1, 0, 0, 0, 0, 1, 0);
        add(0, 8'h00, 1, 2'b01, 1, 0, 3, 1, 1, 0, 0);  // 0-1 wraps to 3
        add(0, 8'h00, 0, 2'b01, 1, 0, 3, 0, 1, 0, 0);
        add(1, 8'hE0, 0, 2'b01, 1, 0, 3, 0, 1, 0, 0);
        add(1, 8'hF0, 0, 2'b01, 1, 0, 3, 0, 1, 0, 0);
        add(1, 8'h6B, 0, 2'b01, 1, 0, 3, 0, 1, 1, 0);
        add(0, 8'h00, 1, 2'b01, 1, 0, 0, 1, 0, 0, 0);  // 3+1 wraps to 0
        add(1, 8'hF0, 0, 2'b01, 1, 0, 0, 0, 0, 0, 0);  // plain release ignored
        add(1, 8'h6B, 0, 2'b01, 1, 0, 0, 0, 0, 0, 0);
        add(1, 8'hE0, 0, 2'b01, 1, 0, 0, 0, 0, 0, 0);  // extended make ignored
        add(1, 8'h6B, 0, 2'b01, 1, 0, 0, 0, 0, 0, 0);
        add(0, 8'h00, 1, 2'b01, 1, 0, 0, 0, 0, 0, 0);  // empty dispatch no-op
        add(1, 8'hE0, 0, 2'b01, 1, 0, 0, 0, 0, 0, 0);
        add(1, 8'hF0, 0, 2'b01, 1, 0, 0, 0, 0, 0, 0);
        add(1, 8'h6B, 1, 2'b01, 1, 0, 0, 0, 0, 1, 0);  // no bypass on empty queue
        add(0, 8'h00, 1, 2'b01, 1, 0, 1, 1, 0, 0, 0);
        add(1, 8'hE0, 0, 2'b01, 1, 0, 1, 0, 0, 0, 0);
        add(1, 8'hF0, 0, 2'b01, 1, 0, 1, 0, 0, 0, 0);
        add(1, 8'h74, 0, 2'b01, 1, 0, 1, 0, 0, 1, 0);
        add(0, 8'h00, 1, 2'b10, 1, 0, 1, 0, 0, 1, 0);  // not play scene
        add(0, 8'h00, 1, 2'b01, 0, 0, 1, 0, 0, 1, 0);  // expand low
        add(0, 8'h00, 1, 2'b11, 1, 0, 0, 1, 1, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].sv, tbl[i].code, tbl[i].fd, tbl[i].scn, tbl[i].ex, tbl[i].sp);
            check_all($sformatf("vec%0d", i), tbl[i].e_people, tbl[i].e_mvv, tbl[i].e_dir,
                      tbl[i].e_qc, tbl[i].e_ovf);
        end

        // Five LEFT commands while expand is low: the fifth overflows.
        for (int k = 1; k <= 5; k++) begin
            byte_in(8'hE0, 1'b0);
            byte_in(8'hF0, 1'b0);
            byte_in(8'h6B, 1'b0);
            check($sformatf("ovf_fill%0d.q_count", k), int'(q_count), (k > 4) ? 4 : k);
            check($sformatf("ovf_fill%0d.overflow", k), int'(overflow), (k > 4) ? 1 : 0);
        end
        for (int k = 1; k <= 5; k++) begin
            drive(1'b0, 8'h00, 1'b1, 2'b01, 1'b1, 1'b0);
            check($sformatf("ovf_frame%0d.people", k), int'(people), (k > 4) ? 0 : k % 4);
            check($sformatf("ovf_frame%0d.mv_valid", k), int'(mv_valid), (k > 4) ? 0 : 1);
            check($sformatf("ovf_frame%0d.q_count", k), int'(q_count), (k > 4) ? 0 : 4 - k);
        end
        check("ovf_sticky", int'(overflow), 1);

        // Three queued, scene change together with frame_done.
        for (int k = 0; k < 3; k++) begin
            byte_in(8'hE0, 1'b0);
            byte_in(8'hF0, 1'b0);
            byte_in(8'h74, 1'b0);
        end
        check("flush_pre.q_count", int'(q_count), 3);
        drive(1'b0, 8'h00, 1'b1, 2'b01, 1'b1, 1'b1);
        check_all("flush", 0, 0, 0, 0, 0);
        drive(1'b0, 8'h00, 1'b0, 2'b01, 1'b1, 1'b0);
        check("flush_after.mv_valid", int'(mv_valid), 0);

        // Reset in the middle of a sequence discards the partial prefix.
        byte_in(8'hE0, 1'b1);
        byte_in(8'hF0, 1'b1);
        do_reset();
        byte_in(8'h6B, 1'b1);
        check("rst_mid.q_count", int'(q_count), 0);
        byte_in(8'hE0, 1'b1);
        byte_in(8'hF0, 1'b1);
        byte_in(8'h6B, 1'b1);
        check("rst_after.q_count", int'(q_count), 1);

        // Randomised run against the reference model.
        do_reset();
        m_people = 0; m_q.delete(); m_ovf = 0; m_mvv = 0; m_dir = 0; m_pre.delete();
        for (int c = 0; c < 3000; c++) begin
            logic       r_sv, r_fd, r_ex, r_sp;
            logic [7:0] r_code;
            logic [1:0] r_scn;
            int         sel;
            r_sv = ($urandom_range(0, 99) < 60);
            sel = $urandom_range(0, 5);
            case (sel)
                0, 1:    r_code = 8'hE0;
                2:       r_code = 8'hF0;
                3:       r_code = 8'h6B;
                4:       r_code = 8'h74;
                default: r_code = 8'($urandom_range(0, 255));
            endcase
            // Keep E0 F0 pairs likely so full commands form often.
            if (sel == 1 && m_pre.size() == 1) r_code = 8'hF0;
            r_fd  = ($urandom_range(0, 99) < 20);
            r_scn = 2'($urandom_range(0, 3));
            r_ex  = ($urandom_range(0, 99) < 70);
            r_sp  = ($urandom_range(0, 99) < 2);
            model_step(r_sv, r_code, r_fd, r_scn, r_ex, r_sp);
            drive(r_sv, r_code, r_fd, r_scn, r_ex, r_sp);
            check_all($sformatf("rnd%0d", c), m_people, int'(m_mvv), int'(m_dir),
                      m_q.size(), int'(m_ovf));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/move_cmd_sched.md
MOVE_CMD_SCHED -- requirements
Module: move_cmd_sched

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, number of queued move commands (power of two, >=2).
REQ-002 Port: clk  input  1  system clock, all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: scan_code  input  8  PS/2 scan-code byte from the keyboard receiver.
REQ-005 Port: scan_valid  input  1  one-cycle strobe; scan_code is valid this cycle.
REQ-006 Port: scene  input  2  current game scene; bit 0 high means the play scene.
REQ-007 Port: scene_posedge  input  1  one-cycle strobe at scene change.
REQ-008 Port: frame_done  input  1  one-cycle strobe at end of each drawn frame.
REQ-009 Port: expand  input  1  building-expand phase active; moves allowed only when high.
REQ-010 Port: people  output  2  current character lane, wraps modulo 4.
REQ-011 Port: mv_valid  output  1  one-cycle pulse when a command updates people.
REQ-012 Port: mv_dir  output  1  direction of the last applied move (0 = left, 1 = right).
REQ-013 Port: q_count  output  clog2(FIFO_DEPTH)+1  number of queued commands.
REQ-014 Port: overflow  output  1  sticky flag: a command was dropped because the queue was full.

Function
REQ-015 Parser FSM states: IDLE, BRK, EXT, EXT_BRK; a state advances only on scan_valid.
REQ-016 IDLE: 0xE0 -> EXT; 0xF0 -> BRK; any other byte -> IDLE.
REQ-017 BRK: any byte -> IDLE, with no command (a plain key release is ignored).
REQ-018 EXT: 0xF0 -> EXT_BRK; any other byte -> IDLE (an extended make code is ignored).
REQ-019 EXT_BRK: 0x6B enqueues LEFT, 0x74 enqueues RIGHT, any other byte enqueues nothing; all bytes -> IDLE.
REQ-020 Enqueue takes effect on the edge that samples the final byte; q_count reflects it on the next cycle.
REQ-021 Dispatch condition: frame_done && scene[0] && expand.
REQ-022 On dispatch with q_count > 0: pop the oldest command and apply it on that edge.
REQ-023 LEFT: people <= people + 1. RIGHT: people <= people - 1. Both are 2-bit wrap-around (3+1=0, 0-1=3).
REQ-024 When a command is applied: mv_valid = 1 for exactly the following cycle, and mv_dir = the popped direction.
REQ-025 Dispatch with an empty queue: no-op; mv_valid stays 0 and people holds.
REQ-026 At most one command is dispatched per frame_done strobe.
REQ-027 Simultaneous enqueue and dispatch, queue non-empty: both occur; q_count is unchanged; FIFO order is preserved.
REQ-028 Simultaneous enqueue and dispatch, queue empty: no bypass; the new command is stored and applied at a later frame.
REQ-029 Enqueue while full with no dispatch: the command is dropped and overflow <= 1.
REQ-030 Enqueue while full with a simultaneous dispatch: the command is accepted (REQ-027).
REQ-031 scene_posedge has highest priority. It sets people <= 0, flushes the queue (q_count <= 0), clears overflow, forces the parser to IDLE and suppresses dispatch and enqueue in that cycle.
REQ-032 When dispatch is disabled (scene[0]=0 or expand=0), commands still enqueue and stay queued.

Reset
REQ-033 While rst_n = 0, asynchronously: people = 0, mv_valid = 0, mv_dir = 0, q_count = 0, overflow = 0, parser = IDLE, FIFO pointers = 0.
REQ-034 Reset deassertion mid-sequence: any partial scan sequence is discarded; the first byte after reset is parsed from IDLE.
REQ-035 FIFO storage contents need no reset; only pointers and count are reset.

Structure
REQ-036 Shared package move_pkg: scan-code constants (0xE0, 0xF0, 0x6B, 0x74), the parser state type, the direction encoding and the default FIFO_DEPTH.
REQ-037 Sub-module move_cmd_fifo: 1-bit wide, FIFO_DEPTH deep, with push/pop/flush, count output and full/empty flags.
REQ-038 The parser FSM and the dispatcher reside in move_cmd_sched.

Verification
REQ-039 Bytes E0,F0,6B, then frame_done with scene=01 and expand=1 -> people 0->1, one mv_valid pulse, mv_dir=0.
REQ-040 people=0, then E0,F0,74 and dispatch -> people=3; with people=3, E0,F0,6B and dispatch -> people=0.
REQ-041 Bytes F0,6B (non-extended) or E0,6B -> q_count stays 0 and no move occurs.
REQ-042 Five LEFT sequences with expand=0, then enable expand and apply 5 frames -> overflow=1, q_count peaks at 4, people = 0->1->2->3->0, the fifth frame is a no-op.
REQ-043 Last byte 6B arrives in the same cycle as frame_done with the queue empty -> no move that frame; people increments at the next frame.
REQ-044 Queue holds 3 entries, scene_posedge pulses together with frame_done -> people=0, q_count=0, overflow=0, no mv_valid pulse.
